udp_rx_parser: RTL
==================

Name: udp_rx_parser

Overview:
- Receive-side counterpart of udp_tx_top.
- Consumes the byte-wide GMII receive stream after RGMII DDR capture, in the 125 MHz domain. Parses preamble/SFD, Ethernet II, IPv4 and UDP headers, filters on local MAC/IP/port, and streams the UDP payload out byte-by-byte.
- Intended to carry host commands back into the ADC capture system, e.g. a start trigger or a config word for the read/write controllers.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, accepted unicast destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- LOCAL_IP, 32'hC0A8_0180 (192.168.1.128), required IPv4 destination address.
- LOCAL_PORT, 16'd4096, required UDP destination port.

Ports:
- clk  in  1  125 MHz receive clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- rx_dv  in  1  GMII receive data valid.
- rx_er  in  1  GMII receive error.
- rx_data  in  8  GMII receive byte.
- udp_rx_data  out  8  payload byte.
- udp_rx_valid  out  1  payload byte strobe.
- udp_rx_last  out  1  marks the final payload byte (coincident with valid).
- udp_rx_abort  out  1  one-cycle pulse: the payload in progress is truncated or errored.
- udp_rx_src_port  out  16  source port of the current datagram; valid from the first payload byte until the next datagram.
- udp_rx_len  out  16  payload length (UDP length − 8); same validity as udp_rx_src_port.
- pkt_drop  out  1  one-cycle pulse when a frame is rejected.
- pkt_count  out  16  count of completed good datagrams; wraps modulo 2^16.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Reset is async assert and synchronous release. Reset mid-frame discards everything; no abort pulse is emitted.
- No backpressure: the downstream block must accept one byte per clk.
- Latency: payload byte sampled on rx_data at cycle N appears on udp_rx_data with udp_rx_valid at cycle N+1.
- State machine:
  - IDLE: wait for rx_dv=1 with rx_data=0x55 → PREAMBLE.
  - PREAMBLE: 0x55 stays. 0xD5 after 1..7 preamble bytes → ETH_HDR. Any other byte, or more than 7 preamble bytes → DRAIN. These cases do not pulse pkt_drop.
  - ETH_HDR: 14 bytes.
    - Destination MAC must equal LOCAL_MAC or broadcast.
    - Ethertype must be 0x0800.
    - On mismatch → DRAIN with pkt_drop.
  - IP_HDR: 20 bytes.
    - Byte 0 must be 0x45; IHL ≠ 5 (IP options) is dropped.
    - Protocol byte must be 17.
    - Destination IP must equal LOCAL_IP.
    - Fragments (MF=1 or fragment offset ≠ 0) are dropped.
    - Header checksum: 16-bit ones-complement accumulate of the 10 words, end-around carry folded each word. The sum must equal 0xFFFF after the last byte. Checked at the 20th byte; failure → DRAIN with pkt_drop.
  - UDP_HDR: 8 bytes.
    - Capture source port.
    - Destination port must equal LOCAL_PORT.
    - Capture length L. L < 9 → DRAIN with pkt_drop; zero-payload datagrams are not delivered.
    - The UDP checksum is ignored.
    - On the 8th byte, load the remaining count = L−8 and update udp_rx_src_port/udp_rx_len.
  - PAYLOAD: emit each byte and decrement the count. The byte at count=1 also asserts udp_rx_last, increments pkt_count, and → DRAIN.
  - DRAIN: ignore bytes (Ethernet padding, FCS, trailing junk) until rx_dv=0 → IDLE.
- The FCS is not checked; the payload is delimited solely by UDP length.
- Boundary conditions:
  - rx_dv falls in any header state: → IDLE with pkt_drop.
  - rx_dv falls in PAYLOAD before the last byte: udp_rx_abort pulses on the next cycle, pkt_drop pulses, no last, pkt_count unchanged → IDLE.
  - rx_er=1 with rx_dv=1 in a header or PAYLOAD state: treated like the truncation cases above (abort only if in PAYLOAD) → DRAIN. In IDLE/DRAIN, rx_er is ignored.
  - rx_dv staying high after the last byte: remains in DRAIN; no new frame starts until rx_dv has been low for at least 1 cycle.
  - pkt_count 0xFFFF + 1 → 0x0000.
- Header byte index: an 8-bit counter, reset on every state entry.

Decomposition:
- udp_rx_pkg:
  - state enum (IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, DRAIN);
  - constants ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, SFD=8'hD5.
- One sub-module: ip_csum_check, the byte-serial ones-complement accumulator with clear, byte-strobe and ok outputs. It is shareable with the transmit path.

Test Plan:
- Good frame: 7×0x55, 0xD5, dst=LOCAL_MAC, IPv4 with correct checksum, dst port 4096, src port 5000, L=12, payload DE AD BE EF, FCS → 4 valid bytes starting 1 cycle after each input byte; last on 0xEF; udp_rx_len=4; udp_rx_src_port=5000; pkt_count=1.
- Filtering: same frame repeated with dst IP 192.168.1.129, then dst port 4097, then ethertype 0x0806 → three pkt_drop pulses, no udp_rx_valid, pkt_count unchanged.
- Checksum: the good frame with one IP checksum bit flipped → pkt_drop at IP byte 20, no payload. The same frame sent to broadcast MAC with a correct checksum → delivered.
- Truncation: L=100 but rx_dv drops after 10 payload bytes → 10 valid bytes, no last, udp_rx_abort 1 cycle, pkt_drop; the next good frame delivers normally.
- Error and reset: rx_er asserted at payload byte 3 → abort and DRAIN. rstn pulsed low during the IP header → outputs return to 0 immediately; the following frame is parsed correctly.
- Padding and wrap: L=9 (1 payload byte, frame padded to 60 bytes) → exactly 1 valid+last byte, padding ignored. With pkt_count preloaded by 65535 good frames, the next good frame → pkt_count=0.

Source files
------------

// File: rtl/udp_rx_pkg.sv
// Shared state encoding and protocol constants for the UDP receive path.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        DRAIN
    } rxState_e;

    localparam logic [7:0]  ETH_HDR_LEN    = 8'd14;
    localparam logic [7:0]  IP_HDR_LEN     = 8'd20;
    localparam logic [7:0]  UDP_HDR_LEN    = 8'd8;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  SFD            = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  MAX_PREAMBLE   = 8'd7;

    // Byte 0 is the least significant byte of the word.
    function automatic logic [7:0] getByte(input logic [47:0] word, input logic [2:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ip_csum_check.sv
// Byte-serial IPv4 header checksum accumulator; ok_o reports whether the running
// ones-complement sum including the current low byte equals 0xFFFF.
module ip_csum_check (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clear_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       ok_o
);

    logic [15:0] sum_q;
    logic [7:0]  hi_q;
    logic        phase_q;
    logic [16:0] wordSum;
    logic [15:0] sum_d;

    // End-around carry is folded on every word so the sum never exceeds 16 bits.
    assign wordSum = {1'b0, sum_q} + {1'b0, hi_q, byte_i};
    assign sum_d   = wordSum[15:0] + {15'd0, wordSum[16]};
    assign ok_o    = phase_q && (sum_d == 16'hFFFF);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sum_q   <= '0;
            hi_q    <= '0;
            phase_q <= 1'b0;
        end else if (clear_i) begin
            sum_q   <= '0;
            phase_q <= 1'b0;
        end else if (byte_valid_i) begin
            if (!phase_q) begin
                hi_q    <= byte_i;
                phase_q <= 1'b1;
            end else begin
                sum_q   <= sum_d;
                phase_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// Receive-side UDP/IPv4 parser: strips preamble and headers from the GMII stream,
// filters on local MAC/IP/port and streams the datagram payload one byte per clock.
module udp_rx_parser
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0180,
    parameter logic [15:0] LOCAL_PORT = 16'd4096
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_dv_i,
    input  logic        rx_er_i,
    input  logic [7:0]  rx_data_i,
    output logic [7:0]  udp_rx_data_o,
    output logic        udp_rx_valid_o,
    output logic        udp_rx_last_o,
    output logic        udp_rx_abort_o,
    output logic [15:0] udp_rx_src_port_o,
    output logic [15:0] udp_rx_len_o,
    output logic        pkt_drop_o,
    output logic [15:0] pkt_count_o
);

    logic [1:0]  rstSync_q;
    logic        rstnInt;
    rxState_e    state_q;
    logic [7:0]  idx_q;
    logic [7:0]  prevByte_q;
    logic        macUcast_q;
    logic        macBcast_q;
    logic        ipMatch_q;
    logic [15:0] srcPort_q;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        last_q;
    logic        abort_q;
    logic        drop_q;
    logic [15:0] outSrcPort_q;
    logic [15:0] outLen_q;
    logic [15:0] pktCount_q;

    logic [15:0] word;
    logic [7:0]  macByte;
    logic [7:0]  ipByte;
    logic        ucastOk;
    logic        bcastOk;
    logic        ipOk;
    logic        csumOk;
    logic        hdrBad;
    logic        hdrLast;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rstSync_q <= 2'b00;
        else         rstSync_q <= {rstSync_q[0], 1'b1};
    end
    assign rstnInt = rstSync_q[1];

    ip_csum_check u_csum (
        .clk_i        (clk_i),
        .rstn_i       (rstnInt),
        .clear_i      (state_q != IP_HDR),
        .byte_valid_i (state_q == IP_HDR && rx_dv_i && !rx_er_i),
        .byte_i       (rx_data_i),
        .ok_o         (csumOk)
    );

    assign word    = {prevByte_q, rx_data_i};
    assign macByte = getByte(LOCAL_MAC, 3'd5 - idx_q[2:0]);
    assign ipByte  = getByte({16'h0000, LOCAL_IP}, 3'd3 - idx_q[2:0]);
    assign ucastOk = macUcast_q && (rx_data_i == macByte);
    assign bcastOk = macBcast_q && (rx_data_i == 8'hFF);
    assign ipOk    = ipMatch_q && (rx_data_i == ipByte);

    always_comb begin
        hdrBad  = 1'b0;
        hdrLast = 1'b0;
        unique case (state_q)
            ETH_HDR: begin
                hdrLast = (idx_q == ETH_HDR_LEN - 8'd1);
                hdrBad  = (idx_q == 8'd5 && !(ucastOk || bcastOk)) ||
                          (hdrLast && word != ETHERTYPE_IPV4);
            end
            IP_HDR: begin
                hdrLast = (idx_q == IP_HDR_LEN - 8'd1);
                hdrBad  = (idx_q == 8'd0 && rx_data_i != IP_VER_IHL) ||
                          (idx_q == 8'd7 && (word & 16'h3FFF) != 16'h0000) ||
                          (idx_q == 8'd9 && rx_data_i != IP_PROTO_UDP) ||
                          (hdrLast && !(ipOk && csumOk));
            end
            UDP_HDR: begin
                hdrLast = (idx_q == UDP_HDR_LEN - 8'd1);
                hdrBad  = (idx_q == 8'd3 && word != LOCAL_PORT) ||
                          (idx_q == 8'd5 && word < 16'd9);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstnInt) begin
        if (!rstnInt) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            prevByte_q   <= '0;
            macUcast_q   <= 1'b0;
            macBcast_q   <= 1'b0;
            ipMatch_q    <= 1'b0;
            srcPort_q    <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            abort_q      <= 1'b0;
            drop_q       <= 1'b0;
            outSrcPort_q <= '0;
            outLen_q     <= '0;
            pktCount_q   <= '0;
        end else begin
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            abort_q    <= 1'b0;
            drop_q     <= 1'b0;
            prevByte_q <= rx_data_i;
            unique case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (rx_dv_i) state_q <= (rx_data_i == PREAMBLE_BYTE) ? PREAMBLE : DRAIN;
                end
                PREAMBLE: begin
                    if (!rx_dv_i) begin
                        state_q <= IDLE;
                    end else if (!rx_er_i && rx_data_i == SFD) begin
                        state_q    <= ETH_HDR;
                        idx_q      <= '0;
                        macUcast_q <= 1'b1;
                        macBcast_q <= 1'b1;
                    end else if (!rx_er_i && rx_data_i == PREAMBLE_BYTE &&
                                 idx_q < MAX_PREAMBLE - 8'd1) begin
                        idx_q <= idx_q + 8'd1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                ETH_HDR, IP_HDR, UDP_HDR: begin
                    if (!rx_dv_i) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b1;
                    end else if (rx_er_i || hdrBad) begin
                        state_q <= DRAIN;
                        drop_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 8'd1;
                        if (state_q == ETH_HDR && idx_q < 8'd6) begin
                            macUcast_q <= ucastOk;
                            macBcast_q <= bcastOk;
                        end
                        if (state_q == IP_HDR && idx_q >= 8'd16) ipMatch_q <= ipOk;
                        if (state_q == UDP_HDR && idx_q == 8'd1) srcPort_q <= word;
                        if (state_q == UDP_HDR && idx_q == 8'd5) len_q <= word;
                        if (hdrLast) begin
                            idx_q <= '0;
                            if (state_q == ETH_HDR) begin
                                state_q   <= IP_HDR;
                                ipMatch_q <= 1'b1;
                            end else if (state_q == IP_HDR) begin
                                state_q <= UDP_HDR;
                            end else begin
                                state_q      <= PAYLOAD;
                                cnt_q        <= len_q - {8'd0, UDP_HDR_LEN};
                                outSrcPort_q <= srcPort_q;
                                outLen_q     <= len_q - {8'd0, UDP_HDR_LEN};
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!rx_dv_i || rx_er_i) begin
                        state_q <= rx_dv_i ? DRAIN : IDLE;
                        abort_q <= 1'b1;
                        drop_q  <= 1'b1;
                    end else begin
                        data_q  <= rx_data_i;
                        valid_q <= 1'b1;
                        if (cnt_q == 16'd1) begin
                            last_q     <= 1'b1;
                            pktCount_q <= pktCount_q + 16'd1;
                            state_q    <= DRAIN;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    idx_q <= '0;
                    if (!rx_dv_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign udp_rx_data_o     = data_q;
    assign udp_rx_valid_o    = valid_q;
    assign udp_rx_last_o     = last_q;
    assign udp_rx_abort_o    = abort_q;
    assign udp_rx_src_port_o = outSrcPort_q;
    assign udp_rx_len_o      = outLen_q;
    assign pkt_drop_o        = drop_q;
    assign pkt_count_o       = pktCount_q;

endmodule
